keypad_scan: RTL

//  Scans a 4x4 hex matrix keypad and debounces it. Registers the last two distinct key presses.

---
 rtl/keypad_pkg.sv | 16 +
 rtl/sync_2ff.sv | 26 ++
 rtl/keypad_scan.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  // KEY_MAP[row][col] gives the hex label printed on the key.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  localparam logic [3:0] COL_RESET = 4'b1110;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser; resets to all ones to match idle pulled-up inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce; keeps the last two confirmed keys.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 4096,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] DigNew,
  output logic [3:0] DigOld,
  output logic       KeyValid
);

  localparam int unsigned MAX_CYCLES =
    (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE    = CW'(2);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [3:0]    row_s;
  kp_state_t     state_q, state_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    dig_new_q, dig_old_q;
  logic          key_valid_q;
  logic [1:0]    row_hit;
  logic          row_low;
  logic          confirm;

  sync_2ff #(
    .WIDTH(4)
  ) u_row_sync (
    .clk  (clk),
    .reset(reset),
    .d    (Row),
    .q    (row_s)
  );

  // Lowest-index low row wins when several rows are pulled low together.
  always_comb begin
    row_hit = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) row_hit = 2'(r);
    end
  end

  assign row_low = !row_s[row_idx_q];

  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    confirm    = 1'b0;
    case (state_q)
      SCAN: begin
        // The first two cycles after a column change are settle time.
        if (scan_cnt_q >= SETTLE && row_s != 4'hF) begin
          state_d    = DEBOUNCE;
          row_idx_d  = row_hit;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + ONE;
        end
      end
      DEBOUNCE: begin
        if (row_low) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d   = HELD;
            deb_cnt_d = '0;
            confirm   = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + ONE;
          end
        end else begin
          state_d    = SCAN;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
        end
      end
      HELD: begin
        if (!row_low) begin
          state_d   = RELEASE;
          deb_cnt_d = '0;
        end
      end
      RELEASE: begin
        if (!row_low) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d    = SCAN;
            deb_cnt_d  = '0;
            scan_cnt_d = '0;
            col_idx_d  = col_idx_q + 2'd1;
          end else begin
            deb_cnt_d = deb_cnt_q + ONE;
          end
        end else begin
          state_d   = HELD;
          deb_cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SCAN;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig_new_q   <= 4'h0;
      dig_old_q   <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= confirm;
      if (confirm) begin
        dig_old_q <= dig_new_q;
        dig_new_q <= KEY_MAP[row_idx_q][col_idx_q];
      end
    end
  end

  // Column index 0 drives COL_RESET; higher indices rotate the single low bit left.
  assign Col      = ~((~COL_RESET) << col_idx_q);
  assign DigNew   = dig_new_q;
  assign DigOld   = dig_old_q;
  assign KeyValid = key_valid_q;

endmodule
